// File: rtl/bcd_key_entry.sv
// Decimal keypad entry into an N-digit BCD register with edge-detected presses,
// overflow tracking and a sequential, saturating BCD-to-binary converter.
module bcd_key_entry #(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            key,
    input  logic                  clr,
    input  logic                  enter,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [2:0]            digit_cnt,
    output logic                  overflow,
    output logic                  busy,
    output logic [BIN_W-1:0]      bin,
    output logic                  valid,
    output logic                  range_err
);

    localparam int BW = 4 * DIGITS;
    localparam int AW = BIN_W + 4;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [AW-1:0] ACC_MAX = {4'b0000, {BIN_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [BW-1:0]    bcd_q, bcd_d;
    logic [2:0]       digit_cnt_q, digit_cnt_d;
    logic             overflow_q, overflow_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             range_err_q, range_err_d;
    logic [9:0]       key_prev_q, key_prev_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             sat_q, sat_d;

    logic          press;
    logic [3:0]    code;
    logic [3:0]    digit;
    logic [AW-1:0] acc_step;

    // Highest-index key wins when several are pressed together
    always_comb begin
        code = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key[i]) begin
                code = 4'(i);
            end
        end
    end

    assign press = (key != 10'd0) && (key_prev_q == 10'd0);

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                digit = bcd_q[4*i +: 4];
            end
        end
    end

    assign acc_step = (acc_q << 3) + (acc_q << 1) + AW'(digit);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (enter) state_d = CONV;
                CONV: if (idx_q == IW'(0)) state_d = DONE;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        busy = (state_q == CONV) || (state_q == DONE);
    end

    // Datapath next values
    always_comb begin
        bcd_d       = bcd_q;
        digit_cnt_d = digit_cnt_q;
        overflow_d  = overflow_q;
        bin_d       = bin_q;
        valid_d     = 1'b0;
        range_err_d = range_err_q;
        key_prev_d  = key;
        acc_d       = acc_q;
        idx_d       = idx_q;
        sat_d       = sat_q;
        if (clr) begin
            bcd_d       = '0;
            digit_cnt_d = 3'd0;
            overflow_d  = 1'b0;
            range_err_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enter) begin
                        acc_d = '0;
                        idx_d = IW'(DIGITS - 1);
                        sat_d = 1'b0;
                    end else if (press) begin
                        if (digit_cnt_q < 3'(DIGITS)) begin
                            bcd_d       = (bcd_q << 4) | BW'(code);
                            digit_cnt_d = digit_cnt_q + 3'd1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
                CONV: begin
                    // Once clamped the accumulator stays at full scale
                    if (sat_q || (acc_step > ACC_MAX)) begin
                        acc_d = ACC_MAX;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = acc_step;
                    end
                    idx_d = idx_q - IW'(1);
                end
                DONE: begin
                    bin_d       = acc_q[BIN_W-1:0];
                    range_err_d = sat_q;
                    valid_d     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // key_prev follows key through reset so a key held across reset is not a press
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q       <= '0;
            digit_cnt_q <= 3'd0;
            overflow_q  <= 1'b0;
            bin_q       <= '0;
            valid_q     <= 1'b0;
            range_err_q <= 1'b0;
            key_prev_q  <= key;
            acc_q       <= '0;
            idx_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            bcd_q       <= bcd_d;
            digit_cnt_q <= digit_cnt_d;
            overflow_q  <= overflow_d;
            bin_q       <= bin_d;
            valid_q     <= valid_d;
            range_err_q <= range_err_d;
            key_prev_q  <= key_prev_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            sat_q       <= sat_d;
        end
    end

    assign bcd       = bcd_q;
    assign digit_cnt = digit_cnt_q;
    assign overflow  = overflow_q;
    assign bin       = bin_q;
    assign valid     = valid_q;
    assign range_err = range_err_q;

endmodule
